sim_adc_slave: RTL
==================

SIM_ADC_SLAVE -- requirements
Module: sim_adc_slave
Purpose: simulated 8-channel 12-bit SPI ADC (ADC128S022 framing) that drives the target platform's ADC_SDAT in the car-hardware simulator, with channel values written by the simulator MCU.

Interface
REQ-001 SHALL have parameter CHANNELS, default 8, number of simulated analog channels (address width 3).
REQ-002 SHALL have parameter DATA_WIDTH, default 12, conversion result width.
REQ-003 SHALL have port sysclk  in  1  single clock for all logic.
REQ-004 SHALL have port sysreset_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port adc_cs_n  in  1  platform chip select, asynchronous to sysclk.
REQ-006 SHALL have port adc_sclk  in  1  platform SPI clock, idles high, asynchronous.
REQ-007 SHALL have port adc_saddr  in  1  platform DIN (channel address), asynchronous.
REQ-008 SHALL have port adc_sdat  out  1  simulated DOUT.
REQ-009 SHALL have port data_in  in  16  MCU write data: [14:12] channel, [11:0] value.
REQ-010 SHALL have port value_load  in  1  one-cycle strobe writing data_in into the channel value table.
REQ-011 SHALL have port frame_cnt  out  16  completed-frame counter.
REQ-012 SHALL have port last_chan  out  3  channel output by the most recently completed frame.
REQ-013 SHALL have port frame_done  out  1  one-cycle pulse per completed frame (event-controller input).

Function
REQ-014 SHALL pass adc_cs_n, adc_sclk, adc_saddr through 2-flop synchronisers; edges are detected on synchronised signals only.
REQ-015 SHALL support each SCLK high/low phase of at least 5 sysclk cycles (SCLK <= 5 MHz at 50 MHz sysclk).
REQ-016 SHALL implement states IDLE and SHIFT; IDLE on reset, and whenever synced cs_n is high.
REQ-017 On synced cs_n fall: go SHIFT, cur_chan <= 0, bit_cnt <= 0, load 16-bit shift register = {4'b0, value[cur_chan=0]}.
REQ-018 In SHIFT, on synced SCLK falling edge n (1..16): adc_sdat presents frame bit 16-n (4 zeros, then D11..D0 MSB first), registered, 1 sysclk after the detected edge.
REQ-019 On synced SCLK rising edges 3, 4, 5 of a frame: sample adc_saddr into next_addr bits 2, 1, 0 respectively.
REQ-020 On rising edge 16: frame complete; last_chan <= cur_chan, cur_chan <= next_addr, frame_cnt += 1 (wraps 0xFFFF -> 0x0000), frame_done pulses next cycle, shift register reloads {4'b0, value[next_addr]}, bit_cnt <= 0; stays SHIFT for back-to-back frames.
REQ-021 adc_sdat SHALL be 0 in IDLE and before the first falling edge of any frame.
REQ-022 Synced cs_n rise mid-frame: abort to IDLE; no frame_done, frame_cnt, last_chan or cur_chan update.
REQ-023 value_load writes value[data_in[14:12]] <= data_in[11:0] next cycle; data_in[15] ignored.
REQ-024 A snapshot taken in the same cycle as value_load uses the pre-write table contents; frames already in flight are unaffected by loads.

Reset
REQ-025 Reset SHALL clear: state=IDLE, value table all 0, cur_chan=0, next_addr=0, last_chan=0, frame_cnt=0, frame_done=0, adc_sdat=0, synchronisers to idle (cs_n=1, sclk=1, saddr=0).
REQ-026 Reset assertion mid-frame SHALL take effect immediately (asynchronous); release is synchronised inside the block.

Configuration
REQ-027 Macro SIM_ADC_NOISE_EN defined: 16-bit Fibonacci LFSR (taps 16,14,13,11), seed 0xACE1 on reset, advances once per completed frame; snapshot bits [1:0] XORed with lfsr[1:0].
REQ-028 SIM_ADC_NOISE_EN undefined: no LFSR logic; output equals table value exactly.

Verification
REQ-029 Load ch0=0xABC; CS low, 16 SCLK at 1 MHz -> master captures 0x0ABC, frame_cnt=1, last_chan=0, one frame_done pulse.
REQ-030 Load ch5=0x123; frame 1 sends DIN address 5, frame 2 back-to-back -> frame 2 returns 0x0123, last_chan=5, frame_cnt=2.
REQ-031 CS rises after 9 SCLKs -> adc_sdat=0, frame_cnt unchanged, no frame_done; next CS fall restarts at channel 0.
REQ-032 Preset 65535 frames then 1 more -> frame_cnt=0x0000, frame_done pulses.
REQ-033 value_load ch0=0x555 same cycle as CS-fall snapshot -> frame returns old value; next frame on ch0 returns 0x0555.
REQ-034 With SIM_ADC_NOISE_EN, ch2=0x800, repeated frames -> bits [11:2] always 0x200, bits [1:0] follow LFSR sequence from seed 0xACE1.

Source files
------------

// File: rtl/sim_adc_slave.sv
// sim_adc_slave: simulated 8-ch 12-bit SPI ADC (ADC128S022 framing) driving ADC_SDAT.
// Ports: sysclk/sysreset_n; adc_cs_n/adc_sclk/adc_saddr (async SPI in), adc_sdat (DOUT);
// data_in/value_load (MCU channel-value writes); frame_cnt/last_chan/frame_done (status).
// Optional macro SIM_ADC_NOISE_EN: 16-bit LFSR noise on result bits [1:0].
module sim_adc_slave #(
  parameter int CHANNELS   = 8,
  parameter int DATA_WIDTH = 12
) (
  input  logic        sysclk,
  input  logic        sysreset_n,
  input  logic        adc_cs_n,
  input  logic        adc_sclk,
  input  logic        adc_saddr,
  output logic        adc_sdat,
  input  logic [15:0] data_in,
  input  logic        value_load,
  output logic [15:0] frame_cnt,
  output logic [2:0]  last_chan,
  output logic        frame_done
);

  localparam int FW = 16;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t state, state_nxt;

  logic rst_meta, rst_n;
  logic [2:0] cs_q, sclk_q;
  logic [1:0] saddr_q;
  logic cs_s, cs_fall, sclk_fall, sclk_rise;
  logic start, abort, fall_en, rise_en, done;

  logic [DATA_WIDTH-1:0] tbl [CHANNELS];
  logic [FW-1:0] sr, snap;
  logic [3:0] bit_cnt;
  logic [2:0] cur_chan, next_addr, snap_chan;
  logic [1:0] noise;
  logic unused_din;

  assign unused_din = data_in[15];

  // reset asserts at once, releases two sysclk edges later
  always_ff @(posedge sysclk or negedge sysreset_n) begin
    if (!sysreset_n) begin
      rst_meta <= 1'b0;
      rst_n    <= 1'b0;
    end else begin
      rst_meta <= 1'b1;
      rst_n    <= rst_meta;
    end
  end

  // [0],[1]: synchroniser, [2]: previous synced value
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      cs_q    <= 3'b111;
      sclk_q  <= 3'b111;
      saddr_q <= 2'b00;
    end else begin
      cs_q    <= {cs_q[1:0], adc_cs_n};
      sclk_q  <= {sclk_q[1:0], adc_sclk};
      saddr_q <= {saddr_q[0], adc_saddr};
    end
  end

  assign cs_s      = cs_q[1];
  assign cs_fall   = cs_q[2] & ~cs_q[1];
  assign sclk_fall = sclk_q[2] & ~sclk_q[1];
  assign sclk_rise = ~sclk_q[2] & sclk_q[1];

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    abort     = 1'b0;
    fall_en   = 1'b0;
    rise_en   = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        if (cs_fall) begin
          state_nxt = SHIFT;
          start     = 1'b1;
        end
      end
      SHIFT: begin
        if (cs_s) begin
          state_nxt = IDLE;
          abort     = 1'b1;
        end else if (sclk_fall) begin
          fall_en = 1'b1;
        end else if (sclk_rise) begin
          if (bit_cnt == 4'd15) done = 1'b1;
          else                  rise_en = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef SIM_ADC_NOISE_EN
  logic [15:0] lfsr, lfsr_nxt;

  // taps 16,14,13,11, shifting toward bit 0
  assign lfsr_nxt = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n)    lfsr <= 16'hACE1;
    else if (done) lfsr <= lfsr_nxt;
  end

  // a reload at frame end already sees the advanced value
  assign noise = done ? lfsr_nxt[1:0] : lfsr[1:0];
`else
  assign noise = 2'b00;
`endif

  // table read is pre-write when a load lands on the snapshot cycle
  assign snap_chan = start ? 3'd0 : next_addr;
  assign snap      = FW'(tbl[snap_chan]) ^ FW'(noise);

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNELS; i++) tbl[i] <= '0;
    end else if (value_load) begin
      tbl[data_in[14:12]] <= data_in[DATA_WIDTH-1:0];
    end
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      sr         <= '0;
      bit_cnt    <= 4'd0;
      cur_chan   <= 3'd0;
      next_addr  <= 3'd0;
      last_chan  <= 3'd0;
      frame_cnt  <= 16'd0;
      frame_done <= 1'b0;
      adc_sdat   <= 1'b0;
    end else begin
      frame_done <= done;
      unique case (1'b1)
        start: begin
          sr       <= snap;
          bit_cnt  <= 4'd0;
          cur_chan <= 3'd0;
          adc_sdat <= 1'b0;
        end
        abort: adc_sdat <= 1'b0;
        fall_en: begin
          adc_sdat <= sr[FW-1];
          sr       <= {sr[FW-2:0], 1'b0};
        end
        rise_en: begin
          bit_cnt <= bit_cnt + 4'd1;
          if (bit_cnt == 4'd2) next_addr[2] <= saddr_q[1];
          if (bit_cnt == 4'd3) next_addr[1] <= saddr_q[1];
          if (bit_cnt == 4'd4) next_addr[0] <= saddr_q[1];
        end
        done: begin
          last_chan <= cur_chan;
          cur_chan  <= next_addr;
          frame_cnt <= frame_cnt + 16'd1;
          sr        <= snap;
          bit_cnt   <= 4'd0;
          adc_sdat  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
